// File: rtl/sev_seg_mux_driver.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS digits at REFRESH_DIV clocks per slot,
// with a shadow/active register pair so every frame is decoded from exactly one load.
module sev_seg_mux_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int HEX_MODE    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzb_en,
  input  logic                    load,
  output logic [7:1]              sev_seg_leds,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  // Display set layout: {lzb_en, blank, dp, digits}
  localparam int SW = DW + 2 * NUM_DIGITS + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [7:1]    SEG_OFF  = 7'b1111111;
  localparam logic [7:1]    SEG_DASH = 7'b0111111;

  function automatic logic [7:1] seg_decode(input logic [3:0] code);
    logic [7:1] seg;
    case (code)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = (HEX_MODE != 0) ? 7'b0001000 : SEG_DASH;
      4'hB:    seg = (HEX_MODE != 0) ? 7'b0000011 : SEG_DASH;
      4'hC:    seg = (HEX_MODE != 0) ? 7'b1000110 : SEG_DASH;
      4'hD:    seg = (HEX_MODE != 0) ? 7'b0100001 : SEG_DASH;
      4'hE:    seg = (HEX_MODE != 0) ? 7'b0000110 : SEG_DASH;
      4'hF:    seg = (HEX_MODE != 0) ? 7'b0001110 : SEG_DASH;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         sh_q, sh_d, act_q, act_d;
  logic [7:1]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q;
  logic                  tc_s, frame_s;
  logic [SW-1:0]         in_set_s;
  logic [DW-1:0]         act_dig_s;
  logic [NUM_DIGITS-1:0] act_dp_s, act_blank_s, lz_s;
  logic                  act_lzb_s;
  logic [3:0]            code_s;
  logic                  dp_sel_s, blank_sel_s;

  assign in_set_s    = {lzb_en, blank_in, dp_in, digits_in};
  assign act_dig_s   = act_q[DW-1:0];
  assign act_dp_s    = act_q[DW +: NUM_DIGITS];
  assign act_blank_s = act_q[DW + NUM_DIGITS +: NUM_DIGITS];
  assign act_lzb_s   = act_q[SW-1];

  // Scan timing and shadow/active buffering next-state.
  always_comb begin
    tc_s    = (pre_q == PRE_LAST);
    frame_s = tc_s && (idx_q == IDX_LAST);
    if (tc_s) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      pre_d = pre_q + 1'b1;
      idx_d = idx_q;
    end
    if (load) begin
      sh_d = in_set_s;
    end else begin
      sh_d = sh_q;
    end
    // A load landing on the boundary edge bypasses the shadow straight into the active set.
    if (frame_s) begin
      act_d = load ? in_set_s : sh_q;
    end else begin
      act_d = act_q;
    end
  end

  // Digit select, leading-zero mask and segment decode for the next output register value.
  always_comb begin
    logic zero_run;
    zero_run    = act_lzb_s;
    lz_s        = '0;
    code_s      = 4'h0;
    dp_sel_s    = 1'b0;
    blank_sel_s = 1'b0;
    an_d        = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_dig_s[4*i +: 4] == 4'h0);
      lz_s[i]  = (i > 0) ? zero_run : 1'b0;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        code_s      = act_dig_s[4*i +: 4];
        dp_sel_s    = act_dp_s[i];
        blank_sel_s = act_blank_s[i] | lz_s[i];
        an_d[i]     = 1'b0;
      end else begin
        an_d[i]     = 1'b1;
      end
    end
    if (blank_sel_s) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      seg_d = seg_decode(code_s);
      dp_d  = ~dp_sel_s;
    end
  end

  // State and output registers; reset wins over a coincident load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      act_q  <= '0;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      act_q  <= act_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      tick_q <= frame_s;
    end
  end

  assign sev_seg_leds = seg_q;
  assign dp_out       = dp_q;
  assign an_out       = an_q;
  assign frame_tick   = tick_q;

endmodule

// File: tb/tb_sev_seg_mux_driver.sv
// Scoreboard bench: two drivers (hex and dash variants) share stimulus; expected frames are
// queued per frame number and a negedge monitor compares every slot of the tagged frames.
module tb_sev_seg_mux_driver;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010, G7 = 7'b1111000, G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000, GB = 7'b0000011, GC = 7'b1000110, GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110, GD = 7'b0111111, GO = 7'b1111111;

  typedef struct packed {
    int              tag;
    logic [3:0][6:0] seg_a;
    logic [3:0][6:0] seg_b;
    logic [3:0]      dp;
  } frame_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic        lzb, load;
  logic [7:1]  seg_a, seg_b;
  logic        dp_a, dp_b, ft_a, ft_b;
  logic [3:0]  an_a, an_b;

  frame_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;

  always #5 clk = ~clk;

  sev_seg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1)) dut_hex (
    .clk(clk), .rst(rst), .digits_in(digits), .dp_in(dp), .blank_in(blank), .lzb_en(lzb),
    .load(load), .sev_seg_leds(seg_a), .dp_out(dp_a), .an_out(an_a), .frame_tick(ft_a));

  sev_seg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0)) dut_dash (
    .clk(clk), .rst(rst), .digits_in(digits), .dp_in(dp), .blank_in(blank), .lzb_en(lzb),
    .load(load), .sev_seg_leds(seg_b), .dp_out(dp_b), .an_out(an_b), .frame_tick(ft_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_frame(input int tag, input logic [27:0] sa, input logic [27:0] sb,
                            input logic [3:0] dpx);
    frame_exp_t e;
    e.tag   = tag;
    e.seg_a = sa;
    e.seg_b = sb;
    e.dp    = dpx;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                         input logic z);
    digits = d;
    dp     = p;
    blank  = b;
    lzb    = z;
    load   = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (ft_a) seen = 1'b1;
    end
    chk("frame_tick_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic chk_off(input string name);
    chk({name, "_seg_a"}, {25'd0, seg_a}, {25'd0, GO});
    chk({name, "_seg_b"}, {25'd0, seg_b}, {25'd0, GO});
    chk({name, "_dp"}, {30'd0, dp_a, dp_b}, 32'd3);
    chk({name, "_an"}, {24'd0, an_a, an_b}, 32'hFF);
    chk({name, "_tick"}, {30'd0, ft_a, ft_b}, 32'd0);
  endtask

  task automatic chk_first(input string name);
    chk({name, "_an"}, {24'd0, an_a, an_b}, 32'hEE);
    chk({name, "_seg_a"}, {25'd0, seg_a}, {25'd0, G0});
    chk({name, "_seg_b"}, {25'd0, seg_b}, {25'd0, G0});
    chk({name, "_dp"}, {30'd0, dp_a, dp_b}, 32'd3);
  endtask

  // Monitor: tracks frame ticks, checks scan order every cycle and slot contents of tagged frames.
  initial begin : monitor
    int         since;
    int         slot;
    bit         have_tick;
    bit         checking;
    frame_exp_t cur;
    logic [3:0] an_exp;
    since     = 0;
    have_tick = 1'b0;
    checking  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        since     = 0;
        have_tick = 1'b0;
        checking  = 1'b0;
        frame_cnt = 0;
      end else if (ft_a) begin
        if (have_tick) chk("frame_period", since + 1, 32'd16);
        chk("tick_an", {24'd0, an_a, an_b}, 32'h77);
        chk("tick_dash_dut", {31'd0, ft_b}, 32'd1);
        have_tick = 1'b1;
        since     = 0;
        frame_cnt++;
        checking  = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].tag == frame_cnt) begin
          cur      = exp_q.pop_front();
          checking = 1'b1;
        end
      end else begin
        since++;
        if (have_tick && since < 16) begin
          slot   = (since - 1) / 4;
          an_exp = ~(4'b0001 << slot);
          chk("scan_an_hex", {28'd0, an_a}, {28'd0, an_exp});
          chk("scan_an_dash", {28'd0, an_b}, {28'd0, an_exp});
          if (checking && (since % 4 == 2)) begin
            chk($sformatf("f%0d_slot%0d_seg_hex", cur.tag, slot), {25'd0, seg_a},
                {25'd0, cur.seg_a[slot]});
            chk($sformatf("f%0d_slot%0d_seg_dash", cur.tag, slot), {25'd0, seg_b},
                {25'd0, cur.seg_b[slot]});
            chk($sformatf("f%0d_slot%0d_dp", cur.tag, slot), {30'd0, dp_a, dp_b},
                {30'd0, cur.dp[slot], cur.dp[slot]});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed loads with hand-decoded expected frames.
  initial begin : stimulus
    rst    = 1'b1;
    load   = 1'b1;
    digits = 16'h9999;
    dp     = 4'hF;
    blank  = 4'h0;
    lzb    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_off("reset");
    rst    = 1'b0;
    load   = 1'b0;
    digits = 16'h0000;
    dp     = 4'h0;
    lzb    = 1'b0;
    push_frame(1, {G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'hF);
    @(posedge clk);
    #1;
    chk_first("release");

    wait_tick();
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    push_frame(frame_cnt + 1, {G1, G2, GA, GF}, {G1, G2, GD, GD}, 4'hF);

    wait_tick();
    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    push_frame(frame_cnt + 1, {GO, GO, G5, G0}, {GO, GO, G5, G0}, 4'hF);

    wait_tick();
    do_load(16'h0050, 4'b0001, 4'h0, 1'b0);
    push_frame(frame_cnt + 1, {G0, G0, G5, G0}, {G0, G0, G5, G0}, 4'b1110);

    wait_tick();
    do_load(16'h8C31, 4'b0110, 4'b0010, 1'b0);
    push_frame(frame_cnt + 1, {G8, GC, GO, G1}, {G8, GD, GO, G1}, 4'b1011);

    wait_tick();
    repeat (15) @(posedge clk);
    #1;
    push_frame(frame_cnt + 1, {G3, GE, G7, GB}, {G3, GD, G7, GD}, 4'hF);
    push_frame(frame_cnt + 2, {G3, GE, G7, GB}, {G3, GD, G7, GD}, 4'hF);
    do_load(16'h3E7B, 4'h0, 4'h0, 1'b0);
    digits = 16'hFFFF;
    dp     = 4'hF;

    wait_tick();
    wait_tick();
    wait_tick();
    do_load(16'h9999, 4'hF, 4'h0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_off("midframe_reset");
    @(posedge clk);
    #1;
    push_frame(1, {G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'hF);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_first("rerelease");

    wait_tick();
    wait_tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sev_seg_mux_driver.md
SEV_SEG_MUX_DRIVER -- requirements
Module: sev_seg_mux_driver

Interface
REQ-001 The block SHALL take parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal range 1..8).
REQ-002 The block SHALL take parameter REFRESH_DIV, default 50000, meaning the clk cycles per digit slot (legal range 2 and up).
REQ-003 The block SHALL take parameter HEX_MODE, default 1: 1 shows glyphs A-F for codes 10-15; 0 shows dash for codes 10-15.
REQ-004 clk  input  1  The single rising-edge clock.
REQ-005 rst  input  1  Reset, synchronous and active-high.
REQ-006 digits_in  input  4*NUM_DIGITS  Packed binary codes; digit i is bits [4i+3:4i]; digit NUM_DIGITS-1 is the most significant.
REQ-007 dp_in  input  NUM_DIGITS  Decimal-point request per digit, active-high.
REQ-008 blank_in  input  NUM_DIGITS  Forced blank per digit, active-high.
REQ-009 lzb_en  input  1  Leading-zero blanking enable, sampled together with the other display inputs.
REQ-010 load  input  1  One-cycle strobe that captures digits_in, dp_in, blank_in and lzb_en into the shadow set.
REQ-011 sev_seg_leds  output  [7:1]  Segments g..a (bit 7 = g, bit 1 = a), active-low, registered.
REQ-012 dp_out  output  1  Decimal-point segment, active-low, registered.
REQ-013 an_out  output  NUM_DIGITS  Digit enables, active-low and one-hot-low, registered.
REQ-014 frame_tick  output  1  One-cycle high pulse marking each frame boundary.

Function
REQ-015 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; terminal count = prescaler at REFRESH_DIV-1.
REQ-016 Digit index SHALL advance by 1 on terminal count and wrap from NUM_DIGITS-1 to 0; the frame boundary is terminal count with index = NUM_DIGITS-1.
REQ-017 Two-level buffering: on load=1, shadow set <= inputs; at frame boundary, active set <= shadow set; display decodes only the active set, so no frame ever mixes two loads.
REQ-018 When load=1 and frame boundary occur in the same cycle, the active set SHALL take the current inputs directly (bypass), and shadow SHALL also take them.
REQ-019 Outputs SHALL be registered from the index with 1-cycle latency: a new index at edge t appears on an_out/sev_seg_leds/dp_out after edge t+1.
REQ-020 an_out SHALL drive bit [index] low and all other bits high; exactly one bit is low at all times after the first post-reset cycle.
REQ-021 Decode (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 Codes 10-15 with HEX_MODE=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; with HEX_MODE=0, dash=0111111.
REQ-023 Leading-zero blank: digit i (i>0) is blanked when active lzb_en=1 and active codes of digits NUM_DIGITS-1 down to i are all 0; digit 0 is never leading-zero blanked.
REQ-024 Blanked digit (forced or leading-zero): sev_seg_leds=1111111 and dp_out=1, while an_out still selects the digit so scan timing is unchanged.
REQ-025 dp_out SHALL be the inverse of active dp_in[index] when the digit is not blanked.
REQ-026 frame_tick SHALL be high in the cycle after the frame boundary edge, coincident with the active set update becoming visible.
REQ-027 NUM_DIGITS=1: index is held at 0 and every terminal count is a frame boundary.

Reset
REQ-028 While rst=1 at a clk edge: prescaler=0, index=0, shadow and active sets=0, sev_seg_leds=1111111, dp_out=1, an_out=all ones, frame_tick=0.
REQ-029 Reset asserted mid-frame SHALL discard any pending shadow content; the first cycle after release drives an_out[0] low with the decode of active digit 0 (code 0, i.e. 1000000).
REQ-030 A load asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-031 Parameters NUM_DIGITS=4, REFRESH_DIV=4: reset, then idle -> an_out cycles 1110,1101,1011,0111 with each value held 4 cycles, and frame_tick pulses once every 16 cycles.
REQ-032 load digits_in=16'h12AF, HEX_MODE=1 -> after the next frame_tick the slots show F=0001110, A=0001000, 2=0100100, 1=1111001 for digits 0..3.
REQ-033 load 16'h0050 with lzb_en=1 -> digits 3 and 2 are blank (1111111), digit 1 shows 0010010, digit 0 shows 1000000; with lzb_en=0, digits 3 and 2 show 1000000.
REQ-034 load issued mid-frame -> the current frame is unchanged; load coincident with the frame boundary -> the new value appears in the next frame (bypass).
REQ-035 HEX_MODE=0 with code 4'hC, plus dp_in[2]=1 and blank_in[1]=1 -> digit shows 0111111; dp_out is 0 only in slot 2; slot 1 is fully dark.
REQ-036 rst pulsed mid-frame after loading 16'h9999 -> outputs are all-off during reset; after release an_out=1110 and sev_seg_leds=1000000.
